// File: rtl/status_led_sequencer.sv
// rtl/status_led_sequencer.sv - board status LED arbiter: fault blink-code > activity flash > heartbeat
// All timing runs off an internal 1 ms tick; led is registered and updates with the state it enters.
module status_led_sequencer #(
  parameter int TICK_DIV     = 50000,
  parameter int HEARTBEAT_MS = 1000,
  parameter int PULSE_MS     = 200,
  parameter int GAP_MS       = 1000,
  parameter int FLASH_MS     = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activity,
  input  logic       fault_req,
  input  logic [3:0] fault_code,
  input  logic       fault_clear,
  output logic       led,
  output logic       fault_active,
  output logic       tick
);

  localparam int DUR_MAX_PF = (PULSE_MS > FLASH_MS) ? PULSE_MS : FLASH_MS;
  localparam int DUR_MAX    = (GAP_MS > DUR_MAX_PF) ? GAP_MS : DUR_MAX_PF;
  localparam int DUR_W      = $clog2(DUR_MAX + 1);
  localparam int HB_W       = $clog2(HEARTBEAT_MS);
  localparam int DIV_W      = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [HB_W-1:0]  HB_LAST    = HB_W'(HEARTBEAT_MS - 1);
  localparam logic [HB_W-1:0]  HB_HALF    = HB_W'(HEARTBEAT_MS / 2);
  localparam logic [DUR_W-1:0] PULSE_LAST = DUR_W'(PULSE_MS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST   = DUR_W'(GAP_MS - 1);
  localparam logic [DUR_W-1:0] FLASH_LAST = DUR_W'(FLASH_MS - 1);

  typedef enum logic [2:0] {
    ST_HB,
    ST_FLASH,
    ST_CODE_ON,
    ST_CODE_OFF,
    ST_CODE_GAP
  } state_t;

  logic [DIV_W-1:0] div_q;
  logic [HB_W-1:0]  hb_q;
  state_t           state_q;
  logic [DUR_W-1:0] dur_q;
  logic [3:0]       cnt_q;
  logic [3:0]       code_q;
  logic [3:0]       pend_q;
  logic             led_q;
  logic             fault_active_q;

  logic             tick_w;
  logic             hb_led;
  logic             req_ok;
  logic             new_code;
  logic [DUR_W-1:0] dur_last;
  logic             timed_done;

  assign tick_w       = (div_q == DIV_LAST);
  assign tick         = tick_w;
  assign led          = led_q;
  assign fault_active = fault_active_q;
  assign hb_led       = (hb_q >= HB_HALF);
  assign new_code     = fault_req && (fault_code != 4'd0);
  // A simultaneous clear always beats a request.
  assign req_ok       = new_code && !fault_clear;

  always_comb begin
    dur_last = FLASH_LAST;
    case (state_q)
      ST_CODE_ON, ST_CODE_OFF: dur_last = PULSE_LAST;
      ST_CODE_GAP:             dur_last = GAP_LAST;
      default:                 dur_last = FLASH_LAST;
    endcase
  end

  assign timed_done = tick_w && (dur_q == dur_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      hb_q  <= '0;
    end else begin
      div_q <= tick_w ? '0 : div_q + 1'b1;
      if (tick_w) begin
        hb_q <= (hb_q == HB_LAST) ? '0 : hb_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_HB;
      dur_q          <= '0;
      cnt_q          <= 4'd0;
      code_q         <= 4'd0;
      pend_q         <= 4'd0;
      led_q          <= 1'b0;
      fault_active_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HB, ST_FLASH: begin
          if (req_ok) begin
            state_q        <= ST_CODE_ON;
            code_q         <= fault_code;
            cnt_q          <= 4'd1;
            dur_q          <= '0;
            fault_active_q <= 1'b1;
            led_q          <= 1'b1;
          end else if (activity) begin
            state_q <= ST_FLASH;
            dur_q   <= '0;
            led_q   <= ~hb_led;
          end else if (state_q == ST_FLASH) begin
            if (timed_done) begin
              state_q <= ST_HB;
              dur_q   <= '0;
              led_q   <= hb_led;
            end else begin
              if (tick_w) begin
                dur_q <= dur_q + 1'b1;
              end
              led_q <= ~hb_led;
            end
          end else begin
            led_q <= hb_led;
          end
        end

        ST_CODE_ON, ST_CODE_OFF, ST_CODE_GAP: begin
          if (fault_clear) begin
            state_q        <= ST_HB;
            dur_q          <= '0;
            cnt_q          <= 4'd0;
            code_q         <= 4'd0;
            pend_q         <= 4'd0;
            fault_active_q <= 1'b0;
            led_q          <= hb_led;
          end else begin
            if (timed_done) begin
              dur_q <= '0;
            end else if (tick_w) begin
              dur_q <= dur_q + 1'b1;
            end

            case (state_q)
              ST_CODE_ON: begin
                if (timed_done) begin
                  state_q <= ST_CODE_OFF;
                  led_q   <= 1'b0;
                end else begin
                  led_q <= 1'b1;
                end
              end
              ST_CODE_OFF: begin
                if (timed_done && (cnt_q < code_q)) begin
                  state_q <= ST_CODE_ON;
                  cnt_q   <= cnt_q + 4'd1;
                  led_q   <= 1'b1;
                end else if (timed_done) begin
                  state_q <= ST_CODE_GAP;
                  led_q   <= 1'b0;
                end else begin
                  led_q <= 1'b0;
                end
              end
              default: begin
                if (timed_done) begin
                  if (pend_q != 4'd0) begin
                    code_q <= pend_q;
                    pend_q <= 4'd0;
                  end
                  state_q <= ST_CODE_ON;
                  cnt_q   <= 4'd1;
                  led_q   <= 1'b1;
                end else begin
                  led_q <= 1'b0;
                end
              end
            endcase

            // A request landing on the gap-exit cycle survives for the following repeat.
            if (new_code) begin
              pend_q <= fault_code;
            end
          end
        end

        default: begin
          state_q <= ST_HB;
          led_q   <= hb_led;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_led_sequencer.sv
// tb/tb_status_led_sequencer.sv - bench for status_led_sequencer
// Reference model tracks modes and a per-code tick schedule rather than the DUT's pulse states.
module tb_status_led_sequencer;

  localparam int TD   = 4;
  localparam int HBMS = 8;
  localparam int PM   = 2;
  localparam int GM   = 6;
  localparam int FM   = 3;

  logic       clk;
  logic       reset;
  logic       activity;
  logic       fault_req;
  logic [3:0] fault_code;
  logic       fault_clear;
  logic       led;
  logic       fault_active;
  logic       tick;

  status_led_sequencer #(
    .TICK_DIV    (TD),
    .HEARTBEAT_MS(HBMS),
    .PULSE_MS    (PM),
    .GAP_MS      (GM),
    .FLASH_MS    (FM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .activity    (activity),
    .fault_req   (fault_req),
    .fault_code  (fault_code),
    .fault_clear (fault_clear),
    .led         (led),
    .fault_active(fault_active),
    .tick        (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass;
  int n_total;
  int rises;
  int ticks_seen;
  bit prev_led;

  // model: mode 0 heartbeat, 1 flash, 2 fault code
  int m_div, m_hb, m_mode, m_fl, m_code, m_pend, m_phase;
  bit m_led, m_fa;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit code_lit(int ph, int code);
    return (ph < 2 * PM * code) && (((ph / PM) % 2) == 0);
  endfunction

  task automatic model_reset();
    m_div = 0; m_hb = 0; m_mode = 0; m_fl = 0;
    m_code = 0; m_pend = 0; m_phase = 0;
    m_led = 1'b0; m_fa = 1'b0;
  endtask

  task automatic model_step(bit a, bit r, int c, bit cl);
    bit t;
    bit hbl;
    t   = (m_div == TD - 1);
    hbl = (m_hb >= HBMS / 2);
    if (m_mode == 2) begin
      if (cl) begin
        m_mode = 0; m_code = 0; m_pend = 0; m_fa = 1'b0; m_led = hbl;
      end else begin
        if (t) begin
          m_phase++;
          if (m_phase == 2 * PM * m_code + GM) begin
            m_phase = 0;
            if (m_pend != 0) begin
              m_code = m_pend;
              m_pend = 0;
            end
          end
        end
        if (r && c != 0) m_pend = c;
        m_led = code_lit(m_phase, m_code);
      end
    end else if (r && c != 0 && !cl) begin
      m_mode = 2; m_code = c; m_phase = 0; m_fa = 1'b1; m_led = 1'b1;
    end else if (a) begin
      m_mode = 1; m_fl = 0; m_led = !hbl;
    end else begin
      if (m_mode == 1 && t) begin
        m_fl++;
        if (m_fl == FM) m_mode = 0;
      end
      m_led = (m_mode == 1) ? !hbl : hbl;
    end
    if (t) m_hb = (m_hb + 1) % HBMS;
    m_div = (m_div + 1) % TD;
  endtask

  task automatic cycle(bit a, bit r, int c, bit cl);
    activity    = a;
    fault_req   = r;
    fault_code  = 4'(c);
    fault_clear = cl;
    @(posedge clk);
    if (reset) model_step(a, r, c, cl);
    else model_reset();
    #1;
    check("led", {7'd0, led}, {7'd0, m_led});
    check("fault_active", {7'd0, fault_active}, {7'd0, m_fa});
    check("tick", {7'd0, tick}, {7'd0, (m_div == TD - 1)});
    if (led && !prev_led) rises++;
    prev_led = led;
    if (tick) ticks_seen++;
    activity    = 1'b0;
    fault_req   = 1'b0;
    fault_clear = 1'b0;
  endtask

  initial begin
    bit ra, rr, rc;
    int rcode;
    n_pass = 0; n_total = 0; rises = 0; ticks_seen = 0; prev_led = 1'b0;
    reset = 1'b0; activity = 1'b0; fault_req = 1'b0; fault_code = 4'd0; fault_clear = 1'b0;
    model_reset();
    #1;
    repeat (3) cycle(0, 0, 0, 0);
    check("reset_led", {7'd0, led}, 8'd0);
    check("reset_tick", {7'd0, tick}, 8'd0);

    // idle heartbeat
    reset = 1'b1;
    ticks_seen = 0;
    repeat (64) cycle(0, 0, 0, 0);
    check("tick_count_64", 8'(ticks_seen), 8'd16);

    // activity flash with retrigger
    cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (30) cycle(0, 0, 0, 0);

    // code 3, then code 1 queued during the second pulse
    cycle(0, 1, 3, 0);
    rises = 0;
    repeat (17) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 0);
    repeat (41) cycle(0, 0, 0, 0);
    check("code3_pulses", 8'(rises + 1), 8'd3);
    repeat (12) cycle(0, 0, 0, 0);
    rises = 0;
    repeat (40) cycle(0, 0, 0, 0);
    check("code1_pulses", 8'(rises), 8'd1);

    // clear mid CODE_ON; clear beats a simultaneous request in HB
    cycle(0, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 0);
    cycle(0, 1, 5, 0);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("clear_fa", {7'd0, fault_active}, 8'd0);
    repeat (5) cycle(0, 0, 0, 0);
    cycle(0, 1, 5, 1);
    repeat (3) cycle(0, 0, 0, 0);
    check("clear_wins_fa", {7'd0, fault_active}, 8'd0);

    // asynchronous reset mid CODE_ON
    cycle(0, 1, 2, 0);
    repeat (2) cycle(0, 0, 0, 0);
    reset = 1'b0;
    #2;
    check("async_led", {7'd0, led}, 8'd0);
    check("async_fa", {7'd0, fault_active}, 8'd0);
    repeat (2) cycle(0, 0, 0, 0);
    reset = 1'b1;
    repeat (40) cycle(0, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      ra    = ($urandom_range(0, 29) == 0);
      rr    = ($urandom_range(0, 79) == 0);
      rc    = ($urandom_range(0, 199) == 0);
      rcode = int'($urandom_range(0, 15));
      cycle(ra, rr, rcode, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/status_led_sequencer.md
Name: status_led_sequencer

Overview:
Owns the single board status LED and shares it between three requesters: a free-running heartbeat, an activity flash, and a fault blink-code. Priority is fault code > activity flash > heartbeat. The block sits at top level between the motion subsystem status signals and the LED pin. All timing derives from an internal 1 ms tick generator.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clk); legal range >= 2
HEARTBEAT_MS, 1000, heartbeat period in ticks; must be even, >= 2
PULSE_MS, 200, fault-code pulse on-time, and the off-time between pulses, in ticks; >= 1
GAP_MS, 1000, dark gap after the last pulse of a code, before the code repeats, in ticks; >= 1
FLASH_MS, 50, activity flash duration in ticks; >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low
activity  input  1  single-cycle pulse requesting an activity flash
fault_req  input  1  single-cycle pulse; latches fault_code
fault_code  input  4  number of blinks, 1..15; 0 is ignored
fault_clear  input  1  single-cycle pulse; ends fault display
led  output  1  registered LED drive, 1 = on
fault_active  output  1  1 while any fault code is latched
tick  output  1  1-cycle 1 ms strobe, exported for other blocks

Behaviour:
- Reset (async, reset low): led=0, fault_active=0, tick=0, state=HB, all counters 0, latched code 0, pending code 0.
- Tick generator: div counter 0..TICK_DIV-1, wraps. tick=1 for exactly the cycle in which the counter equals TICK_DIV-1.
- Heartbeat: hb counter advances on tick, range 0..HEARTBEAT_MS-1, wraps, and runs in every state. hb_led = (hb >= HEARTBEAT_MS/2).
- States: HB, FLASH, CODE_ON, CODE_OFF, CODE_GAP. led is registered and reflects the state/counters of the previous cycle (1-cycle latency).
- HB:
  - led <= hb_led.
  - fault_req with nonzero code: latch code, set fault_active, go to CODE_ON. Pulse count = 1, dur = 0.
  - Otherwise, activity: go to FLASH with dur = 0.
- FLASH:
  - led <= ~hb_led.
  - dur increments on tick; leave for HB when dur reaches FLASH_MS-1 on a tick.
  - activity during FLASH restarts dur = 0 (retrigger).
  - fault_req with nonzero code pre-empts: go to CODE_ON, as from HB.
- CODE_ON: led <= 1. After PULSE_MS ticks, go to CODE_OFF.
- CODE_OFF: led <= 0. After PULSE_MS ticks:
  - if pulse count < code: increment count, go to CODE_ON;
  - else go to CODE_GAP.
- CODE_GAP: led <= 0. After GAP_MS ticks, load code from pending if pending is nonzero, clear pending, set count = 1, go to CODE_ON.
- Duration counter: reset to 0 on every state entry; each timed state lasts exactly N ticks.
- fault_req while a fault is displayed: nonzero code is written to pending. Last write wins. It takes effect only at the next CODE_GAP exit, so the sequence in progress is never truncated.
- activity is ignored while fault_active=1.
- fault_clear from any CODE_* state: next cycle state=HB, fault_active=0, latched and pending codes cleared, led follows hb_led.
- fault_clear in HB or FLASH: no effect.
- fault_clear and fault_req asserted in the same cycle: clear wins and the req is dropped.
- fault_req with code 0: ignored everywhere.
- Widths: duration counter wide enough for max(PULSE_MS, GAP_MS, FLASH_MS); hb counter clog2(HEARTBEAT_MS); div counter clog2(TICK_DIV). No overflow is permitted within legal parameter ranges.
- Reset asserted mid-sequence: immediate return to reset values. No code survives reset.

Test Plan:
Bench parameters: TICK_DIV=4, HEARTBEAT_MS=8, PULSE_MS=2, GAP_MS=6, FLASH_MS=3.
1. Release reset, idle 64 cycles -> tick every 4th cycle; led low for 16 cycles then high for 16 cycles, repeating; fault_active=0.
2. activity pulse at heartbeat-low -> led goes high 1 cycle later for 3 ticks (12 cycles +/- tick phase), then resumes heartbeat. Second pulse mid-flash extends the flash by a full 3 ticks from the retrigger.
3. fault_req with code=3 -> fault_active=1; led pattern is on 2 / off 2 / on 2 / off 2 / on 2 / off 2 / off 6 ticks, repeating; exactly 3 pulses per period of 18 ticks.
4. During the code-3 display, fault_req code=1 on the second pulse -> the current sequence completes with 3 pulses; after the gap, single pulses repeat.
5. fault_clear mid CODE_ON -> next cycle fault_active=0, led equals hb_led. Simultaneous fault_req code=5 plus fault_clear in HB -> no fault latched.
6. Drive reset low mid CODE_ON -> led=0 and fault_active=0 asynchronously. After release, heartbeat restarts from hb=0 and no code resumes.
